// File: rtl/cavlc_level_reader_pkg.sv
// cavlc_level_reader_pkg: state encoding and saturation helper for the CAVLC level reader.
package cavlc_level_reader_pkg;
   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_CAPTURE,
      S_EMIT0,
      S_EMIT1,
      S_DONE
   } state_t;
   function automatic logic [4:0] sat5(input logic [4:0] v, input logic [4:0] m);
      return (v > m) ? m : v;
   endfunction
endpackage

// File: rtl/cavlc_level_reader.sv
// cavlc_level_reader: fetches block levels two per buffer read and streams them
// one at a time with index, trailing-one and last tags over valid/ready.
module cavlc_level_reader
   import cavlc_level_reader_pkg::*;
#(
   parameter int DATAWIDTH = 8,
   parameter int ADDRWIDTH = 4,
   parameter int DEPTH     = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [4:0]           total_coeff,
   input  logic [1:0]           trailing_ones,
   output logic                 busy,
   output logic [ADDRWIDTH-1:0] buf_raddr,
   output logic                 buf_re,
   input  logic [DATAWIDTH-1:0] buf_out0,
   input  logic [DATAWIDTH-1:0] buf_out1,
   output logic                 lvl_valid,
   input  logic                 lvl_ready,
   output logic [DATAWIDTH-1:0] lvl_data,
   output logic [4:0]           lvl_idx,
   output logic                 lvl_t1,
   output logic                 lvl_last,
   output logic                 done
);
   localparam logic [4:0] MAX_COEFF = 5'(DEPTH);
   state_t               state_q, state_d;
   logic [4:0]           tc_q, tc_d, idx_q, idx_d, tc_c, t1_c;
   logic [1:0]           t1_q, t1_d;
   logic [ADDRWIDTH-1:0] ptr_q, ptr_d;
   logic [DATAWIDTH-1:0] hold0_q, hold0_d, hold1_q, hold1_d;
   logic                 hs;
   assign tc_c      = sat5(total_coeff, MAX_COEFF);
   assign t1_c      = sat5({3'b0, trailing_ones}, tc_c);
   assign busy      = state_q != S_IDLE;
   assign buf_re    = state_q == S_ISSUE;
   assign buf_raddr = buf_re ? ptr_q : '0;
   assign lvl_valid = (state_q == S_EMIT0) || (state_q == S_EMIT1);
   assign lvl_data  = (state_q == S_EMIT0) ? hold0_q : (state_q == S_EMIT1) ? hold1_q : '0;
   assign lvl_idx   = lvl_valid ? idx_q : '0;
   assign lvl_t1    = lvl_valid && (idx_q < {3'b0, t1_q});
   assign lvl_last  = lvl_valid && (idx_q == tc_q - 5'd1);
   assign done      = state_q == S_DONE;
   assign hs        = lvl_valid && lvl_ready;
   always_comb begin
      state_d = state_q;
      tc_d    = tc_q;
      t1_d    = t1_q;
      ptr_d   = ptr_q;
      idx_d   = idx_q;
      hold0_d = hold0_q;
      hold1_d = hold1_q;
      case (state_q)
         S_IDLE: if (start) begin
            tc_d    = tc_c;
            t1_d    = t1_c[1:0];
            ptr_d   = '0;
            idx_d   = '0;
            state_d = (tc_c == 5'd0) ? S_DONE : S_ISSUE;
         end
         S_ISSUE: state_d = S_CAPTURE;
         S_CAPTURE: begin
            hold0_d = buf_out0;
            hold1_d = buf_out1;
            state_d = S_EMIT0;
         end
         S_EMIT0: if (hs) begin
            idx_d   = idx_q + 5'd1;
            state_d = lvl_last ? S_DONE : S_EMIT1;
         end
         S_EMIT1: if (hs) begin
            idx_d   = idx_q + 5'd1;
            ptr_d   = ptr_q + ADDRWIDTH'(2);
            state_d = lvl_last ? S_DONE : S_ISSUE;
         end
         default: state_d = S_IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         tc_q    <= '0;
         t1_q    <= '0;
         ptr_q   <= '0;
         idx_q   <= '0;
         hold0_q <= '0;
         hold1_q <= '0;
      end else begin
         state_q <= state_d;
         tc_q    <= tc_d;
         t1_q    <= t1_d;
         ptr_q   <= ptr_d;
         idx_q   <= idx_d;
         hold0_q <= hold0_d;
         hold1_q <= hold1_d;
      end
   end
endmodule

// File: tb/tb_cavlc_level_reader.sv
// tb_cavlc_level_reader: randomized and directed checks of the level reader
// against a queue-free list model of the block's level stream.
module tb_cavlc_level_reader;
   logic             clk = 0, rst = 1, start = 0, lvl_ready = 0;
   logic [4:0]       total_coeff = 0;
   logic [1:0]       trailing_ones = 0;
   logic             busy, buf_re, lvl_valid, lvl_t1, lvl_last, done;
   logic [3:0]       buf_raddr;
   logic [7:0]       buf_out0 = 0, buf_out1 = 0, lvl_data;
   logic [4:0]       lvl_idx;
   logic signed [7:0] mem [16];
   int               n_cmp = 0, n_bad = 0;

   cavlc_level_reader dut (
      .clk(clk), .rst(rst), .start(start), .total_coeff(total_coeff),
      .trailing_ones(trailing_ones), .busy(busy), .buf_raddr(buf_raddr),
      .buf_re(buf_re), .buf_out0(buf_out0), .buf_out1(buf_out1),
      .lvl_valid(lvl_valid), .lvl_ready(lvl_ready), .lvl_data(lvl_data),
      .lvl_idx(lvl_idx), .lvl_t1(lvl_t1), .lvl_last(lvl_last), .done(done)
   );

   always #5 clk = ~clk;

   // behavioural level buffer: one-cycle read of mem[a] and mem[a+1]
   always @(posedge clk) if (buf_re) begin
      buf_out0 <= mem[buf_raddr];
      buf_out1 <= mem[4'(buf_raddr + 4'd1)];
   end

   task automatic check(input string tag, input int got, input int exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_busy"}, int'(busy), 0);
      check({tag, "_re"}, int'(buf_re), 0);
      check({tag, "_raddr"}, int'(buf_raddr), 0);
      check({tag, "_valid"}, int'(lvl_valid), 0);
      check({tag, "_data"}, int'(lvl_data), 0);
      check({tag, "_idx"}, int'(lvl_idx), 0);
      check({tag, "_t1"}, int'(lvl_t1), 0);
      check({tag, "_last"}, int'(lvl_last), 0);
      check({tag, "_done"}, int'(done), 0);
   endtask

   // mode: 0 ready high, 1 ready 1-0-0-1, 2 random ready, 3 ready high + mid-block start
   task automatic run_block(input int tc_in, input int t1_in, input int mode, input int rst_at);
      int tcc, t1c, cyc, k, rd, exp_done;
      bit got_done, stall;
      int s_data, s_idx, s_t1, s_last;
      tcc = (tc_in > 16) ? 16 : tc_in;
      t1c = (t1_in > tcc) ? tcc : t1_in;
      exp_done = (tcc == 0) ? 1 : 4 * ((tcc + 1) / 2) - (tcc % 2) + 1;
      @(posedge clk); #1;
      start = 1; total_coeff = 5'(tc_in); trailing_ones = 2'(t1_in);
      @(posedge clk); #1;
      start = 0; total_coeff = 5'($urandom); trailing_ones = 2'($urandom);
      cyc = 1; k = 0; rd = 0; got_done = 0; stall = 0;
      s_data = 0; s_idx = 0; s_t1 = 0; s_last = 0;
      check("busy_after_start", int'(busy), 1);
      while (!got_done && cyc < 300) begin
         lvl_ready = (mode == 1) ? ((cyc % 4 == 0) || (cyc % 4 == 3)) :
                     (mode == 2) ? 1'($urandom) : 1'b1;
         if (mode == 3) begin
            start = (cyc == 5);
            total_coeff = 5'd2; trailing_ones = 2'd0;
         end
         if (rst_at >= 0 && lvl_valid && int'(lvl_idx) == rst_at) begin
            rst = 1;
            @(posedge clk); #1;
            rst = 0;
            check_idle_outputs("mid_rst");
            @(posedge clk); #1;
            check("mid_rst_no_done", int'(done), 0);
            return;
         end
         if (buf_re) begin
            check("raddr", int'(buf_raddr), 2 * rd);
            rd++;
         end
         if (stall) begin
            check("stall_valid", int'(lvl_valid), 1);
            check("stall_data", int'($signed(lvl_data)), s_data);
            check("stall_idx", int'(lvl_idx), s_idx);
            check("stall_t1", int'(lvl_t1), s_t1);
            check("stall_last", int'(lvl_last), s_last);
         end
         stall = 0;
         if (lvl_valid) begin
            if (k < tcc) begin
               s_data = mem[k]; s_idx = k; s_t1 = int'(k < t1c); s_last = int'(k == tcc - 1);
               if (lvl_ready) begin
                  check("data", int'($signed(lvl_data)), s_data);
                  check("idx", int'(lvl_idx), s_idx);
                  check("t1", int'(lvl_t1), s_t1);
                  check("last", int'(lvl_last), s_last);
                  k++;
               end else stall = 1;
            end else check("extra_level", k, tcc - 1);
         end
         if (done) begin
            got_done = 1;
            check("level_count", k, tcc);
            check("read_count", rd, (tcc + 1) / 2);
            if (mode == 0 || mode == 3) check("done_cycle", cyc, exp_done);
         end
         @(posedge clk); #1;
         cyc++;
      end
      start = 0;
      if (!got_done) check("done_timeout", cyc, exp_done);
      check("done_pulse_width", int'(done), 0);
      check("busy_after_done", int'(busy), 0);
   endtask

   initial begin
      for (int i = 0; i < 16; i++) mem[i] = 0;
      repeat (3) @(posedge clk);
      #1;
      check_idle_outputs("reset");
      rst = 0;
      run_block(0, 2, 0, -1);
      mem[0] = 5; mem[1] = -3; mem[2] = 1; mem[3] = -1; mem[4] = 1; mem[5] = 77;
      run_block(5, 3, 0, -1);
      run_block(5, 3, 1, -1);
      for (int i = 0; i < 16; i++) mem[i] = 8'(i + 1);
      run_block(16, 3, 0, -1);
      run_block(6, 1, 3, -1);
      run_block(8, 2, 0, 2);
      run_block(4, 3, 0, -1);
      for (int b = 0; b < 30; b++) begin
         for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
         run_block(int'($urandom_range(0, 20)), int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), -1);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
